// File: rtl/muldiv_pkg.sv
// Shared types, constants and op-decode helpers for the EX-stage mul/div unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } md_state_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic is_div(input md_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_rem(input md_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  // MULHSU treats only rs1 as signed
  function automatic logic is_signed_a(input md_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input md_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared iterative datapath: 64-bit {hi,lo} shift register plus a 33-bit
// add/subtract. Multiply is LSB-first shift-add, divide is MSB-first restoring.
module muldiv_iter
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_en,
  input  logic            i_div,
  input  logic [XLEN-1:0] i_opa,
  input  logic [XLEN-1:0] i_opb,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_den;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN:0]   w_add_a;
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  // Remainder shifted left by one with the next dividend bit brought in
  assign w_div_shift = {r_hi, r_lo[XLEN-1]};
  assign w_add_a     = i_div ? w_div_shift : {1'b0, r_hi};
  // 33-bit trial: bit XLEN is the carry (multiply) or borrow (divide)
  assign w_sum       = i_div ? (w_add_a - {1'b0, r_den}) : (w_add_a + {1'b0, r_den});

  // One iteration step of either algorithm
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (i_div) begin
      if (!w_sum[XLEN]) begin
        w_hi_nxt = w_sum[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_div_shift[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      if (r_lo[0]) begin
        w_hi_nxt = w_sum[XLEN:1];
        w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
      end else begin
        w_hi_nxt = {1'b0, r_hi[XLEN-1:1]};
        w_lo_nxt = {r_hi[0], r_lo[XLEN-1:1]};
      end
    end
  end

  // Load clears the accumulator and captures operands; enable advances one step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_den <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_opa;
      r_den <= i_opb;
    end else if (i_en) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M multiply/divide unit: FSM, operand sign handling and result select.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_t       r_state;
  md_state_t       w_state_nxt;
  md_op_t          r_op;
  logic [4:0]      r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_special;
  logic [XLEN-1:0] r_spec_val;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  md_op_t          w_op;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div0;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_spec_val;
  logic            w_accept;
  logic [XLEN-1:0] w_hi;
  logic [XLEN-1:0] w_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fin_val;

  assign w_op      = md_op_t'(op);
  assign w_sa      = is_signed_a(w_op) & a[XLEN-1];
  assign w_sb      = is_signed_b(w_op) & b[XLEN-1];
  assign w_mag_a   = w_sa ? (~a + {{(XLEN-1){1'b0}}, 1'b1}) : a;
  assign w_mag_b   = w_sb ? (~b + {{(XLEN-1){1'b0}}, 1'b1}) : b;
  assign w_div0    = is_div(w_op) & (b == {XLEN{1'b0}});
  assign w_ovf     = is_div(w_op) & is_signed_b(w_op) & (a == {1'b1, {(XLEN-1){1'b0}}})
                     & (b == {XLEN{1'b1}});
  assign w_special = w_div0 | w_ovf;
  assign w_accept  = (r_state == ST_IDLE) & start & ~flush;

  // Architecturally defined results for divide-by-zero and signed overflow
  always_comb begin
    w_spec_val = '0;
    if (w_div0) begin
      w_spec_val = is_rem(w_op) ? a : {XLEN{1'b1}};
    end else begin
      w_spec_val = is_rem(w_op) ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  muldiv_iter u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_en   (r_state == ST_CALC),
    .i_div  (is_div(r_op)),
    .i_opa  (w_mag_a),
    .i_opb  (w_mag_b),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  // Sign fix-up of magnitude results and funct3 result select
  always_comb begin
    w_prod    = r_neg_q ? (~{w_hi, w_lo} + {{(2*XLEN-1){1'b0}}, 1'b1}) : {w_hi, w_lo};
    w_quo     = r_neg_q ? (~w_lo + {{(XLEN-1){1'b0}}, 1'b1}) : w_lo;
    w_rem     = r_neg_r ? (~w_hi + {{(XLEN-1){1'b0}}, 1'b1}) : w_hi;
    w_fin_val = '0;
    if (r_special) begin
      w_fin_val = r_spec_val;
    end else begin
      case (r_op)
        OP_MUL:                       w_fin_val = w_prod[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: w_fin_val = w_prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              w_fin_val = w_quo;
        OP_REM, OP_REMU:              w_fin_val = w_rem;
        default:                      w_fin_val = '0;
      endcase
    end
  end

  // Next-state logic; flush wins over everything, including start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_special ? ST_FIN : ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_cnt == 5'd31) begin
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operation context, iteration counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_MUL;
      r_cnt      <= 5'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op       <= w_op;
        r_cnt      <= 5'd0;
        r_neg_q    <= w_sa ^ w_sb;
        r_neg_r    <= w_sa;
        r_special  <= w_special;
        r_spec_val <= w_spec_val;
      end else if (r_state == ST_CALC) begin
        r_cnt <= r_cnt + 5'd1;
      end
      if ((r_state == ST_FIN) && !flush) begin
        r_done   <= 1'b1;
        r_result <= w_fin_val;
      end
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule
